// File: rtl/soc_bus_router.sv
// Data-side interconnect: decodes core accesses onto NUM_SLAVES targets with registered routing,
// per-slave ready handshake, a wait timeout and bus errors for unmapped addresses.
module soc_bus_router #(
  parameter int unsigned NUM_SLAVES     = 4,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = {4{32'hF000_0000}},
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             m_req_i,
  input  logic [ADDR_WIDTH-1:0]            m_addr_i,
  input  logic [DATA_WIDTH-1:0]            m_wdata_i,
  input  logic                             m_wen_i,
  input  logic [DATA_WIDTH/8-1:0]          m_byte_en_i,
  output logic [DATA_WIDTH-1:0]            m_rdata_o,
  output logic                             m_ready_o,
  output logic                             m_err_o,
  output logic [NUM_SLAVES-1:0]            s_req_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  output logic                             s_wen_o,
  output logic [DATA_WIDTH/8-1:0]          s_byte_en_o,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata_i,
  input  logic [NUM_SLAVES-1:0]            s_ready_i,
  output logic [7:0]                       err_count_o
);

  localparam int unsigned BeW  = DATA_WIDTH / 8;
  localparam int unsigned IdxW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] CntLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic [15:0]             cnt_q;
  logic [NUM_SLAVES-1:0]   s_req_q;
  logic [ADDR_WIDTH-1:0]   s_addr_q;
  logic [DATA_WIDTH-1:0]   s_wdata_q;
  logic                    s_wen_q;
  logic [BeW-1:0]          s_be_q;
  logic [DATA_WIDTH-1:0]   m_rdata_q;
  logic                    m_ready_q;
  logic                    m_err_q;
  logic [7:0]              err_cnt_q;

  logic                    hit;
  logic [IdxW-1:0]         hit_idx;
  logic [ADDR_WIDTH-1:0]   hit_mask;
  logic                    sel_ready;
  logic [DATA_WIDTH-1:0]   sel_rdata;
  logic [7:0]              err_cnt_inc;

  // Priority decode: the first (lowest-index) matching region wins on overlap.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_mask = '0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!hit && ((m_addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
                   SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit      = 1'b1;
        hit_idx  = IdxW'(i);
        hit_mask = SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  always_comb begin
    sel_ready   = s_ready_i[idx_q];
    sel_rdata   = s_rdata_i[idx_q*DATA_WIDTH +: DATA_WIDTH];
    err_cnt_inc = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      cnt_q     <= '0;
      s_req_q   <= '0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_wen_q   <= 1'b0;
      s_be_q    <= '0;
      m_rdata_q <= '0;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      m_ready_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (m_req_i) begin
            if (hit) begin
              idx_q     <= hit_idx;
              s_req_q   <= NUM_SLAVES'(1) << hit_idx;
              s_addr_q  <= m_addr_i & ~hit_mask;
              s_wdata_q <= m_wdata_i;
              s_wen_q   <= m_wen_i;
              s_be_q    <= m_byte_en_i;
              cnt_q     <= '0;
              state_q   <= StWait;
            end else begin
              m_err_q   <= 1'b1;
              m_rdata_q <= '0;
              m_ready_q <= 1'b1;
              err_cnt_q <= err_cnt_inc;
              state_q   <= StResp;
            end
          end
        end
        StWait: begin
          // Ready on the timeout boundary cycle still counts as success.
          if (sel_ready) begin
            m_rdata_q <= s_wen_q ? '0 : sel_rdata;
            s_req_q   <= '0;
            s_wen_q   <= 1'b0;
            m_err_q   <= 1'b0;
            m_ready_q <= 1'b1;
            state_q   <= StResp;
          end else if (cnt_q == CntLast) begin
            m_rdata_q <= '0;
            s_req_q   <= '0;
            s_wen_q   <= 1'b0;
            m_err_q   <= 1'b1;
            m_ready_q <= 1'b1;
            err_cnt_q <= err_cnt_inc;
            state_q   <= StResp;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        StResp: begin
          m_err_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_rdata_o   = m_rdata_q;
  assign m_ready_o   = m_ready_q;
  assign m_err_o     = m_err_q;
  assign s_req_o     = s_req_q;
  assign s_addr_o    = s_addr_q;
  assign s_wdata_o   = s_wdata_q;
  assign s_wen_o     = s_wen_q;
  assign s_byte_en_o = s_be_q;
  assign err_count_o = err_cnt_q;

endmodule
